// File: rtl/spike_serializer_out.sv
// Spike frame serializer: queues core spike frames and streams them
// out LSB-beat-first, with a registered bypass for chip daisy-chaining.
module spike_serializer_out #(
  parameter int SPIKE_WIDTH = 16,
  parameter int IO_WIDTH    = 8,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   BP,
  input  logic                   IN_VALID,
  input  logic [IO_WIDTH-1:0]    IN_SPIKE,
  input  logic                   FRAME_VALID,
  input  logic [SPIKE_WIDTH-1:0] FRAME_SPIKE,
  output logic                   FRAME_READY,
  output logic                   OUT_VALID,
  output logic [IO_WIDTH-1:0]    OUT_SPIKE,
  input  logic                   OUT_READY,
  output logic                   BUSY,
  output logic                   OVERFLOW
);

  localparam int NBEATS = SPIKE_WIDTH / IO_WIDTH;
  localparam int CW = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] C_LAST = CW'(NBEATS - 1);

  logic [SPIKE_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]            r_wp;
  logic [AW:0]            r_rp;
  logic [SPIKE_WIDTH-1:0] r_sh;
  logic [CW-1:0]          r_cnt;
  logic                   r_ser_v;
  logic                   r_byp_v;
  logic [IO_WIDTH-1:0]    r_byp_d;
  logic                   r_ovf;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_load;
  logic w_adv;
  logic w_last;

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW] != r_rp[AW]) &&
                   (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_push  = FRAME_VALID && FRAME_READY;
  assign w_last  = (r_cnt == C_LAST);
  assign w_adv   = r_ser_v && OUT_READY && !BP;
  // A frame is loaded into an idle serializer or right behind the last beat.
  assign w_load  = !w_empty && !BP &&
                   (!r_ser_v || (w_adv && w_last));

  assign FRAME_READY = !BP && !w_full;
  assign OUT_VALID   = BP ? r_byp_v : r_ser_v;
  assign OUT_SPIKE   = BP ? r_byp_d : r_sh[IO_WIDTH-1:0];
  assign BUSY        = !w_empty || r_ser_v;
  assign OVERFLOW    = r_ovf;

  // Frame storage; contents need no reset, the pointers gate validity.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wp[AW-1:0]] <= FRAME_SPIKE;
    end
  end

  // FIFO pointers with an extra wrap bit for full/empty.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_load) r_rp <= r_rp + 1'b1;
    end
  end

  // Shift register, beat counter and valid flag of the serializer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sh    <= '0;
      r_cnt   <= '0;
      r_ser_v <= 1'b0;
    end else if (w_load) begin
      r_sh    <= r_mem[r_rp[AW-1:0]];
      r_cnt   <= '0;
      r_ser_v <= 1'b1;
    end else if (w_adv) begin
      if (!w_last) begin
        r_sh  <= r_sh >> IO_WIDTH;
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_ser_v <= 1'b0;
      end
    end
  end

  // Upstream chain beat registered every edge for the bypass path.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_byp_v <= 1'b0;
      r_byp_d <= '0;
    end else begin
      r_byp_v <= IN_VALID;
      r_byp_d <= IN_SPIKE;
    end
  end

  // Sticky flag for a frame refused while not in bypass.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ovf <= 1'b0;
    end else if (FRAME_VALID && !FRAME_READY && !BP) begin
      r_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spike_serializer_out.sv
// Bench for spike_serializer_out: directed scenarios plus random traffic
// on a 16/8 and a 32/4 instance, checked against a frame-queue model.
module tb_spike_serializer_out;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bp = 1'b0;
  logic        iv = 1'b0;
  logic [7:0]  is = '0;
  logic        fv = 1'b0;
  logic [31:0] fs = '0;
  logic        ordy = 1'b0;

  logic       fr0, ov0, busy0, ovf0;
  logic [7:0] sp0;
  logic       fr1, ov1, busy1, ovf1;
  logic [3:0] sp1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  spike_serializer_out dut0 (
    .CLK(clk), .RST(rst), .BP(bp),
    .IN_VALID(iv), .IN_SPIKE(is),
    .FRAME_VALID(fv), .FRAME_SPIKE(fs[15:0]),
    .FRAME_READY(fr0), .OUT_VALID(ov0),
    .OUT_SPIKE(sp0), .OUT_READY(ordy),
    .BUSY(busy0), .OVERFLOW(ovf0)
  );

  spike_serializer_out #(
    .SPIKE_WIDTH(32), .IO_WIDTH(4), .FIFO_DEPTH(2)
  ) dut1 (
    .CLK(clk), .RST(rst), .BP(bp),
    .IN_VALID(iv), .IN_SPIKE(is[3:0]),
    .FRAME_VALID(fv), .FRAME_SPIKE(fs),
    .FRAME_READY(fr1), .OUT_VALID(ov1),
    .OUT_SPIKE(sp1), .OUT_READY(ordy),
    .BUSY(busy1), .OVERFLOW(ovf1)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: per instance a 2-frame queue, the frame being
  // sent with its beat index, and the registered bypass beat.
  int          NB [2] = '{2, 8};
  int          IW [2] = '{8, 4};
  logic [31:0] FM [2] = '{32'h0000_FFFF, 32'hFFFF_FFFF};
  logic [31:0] mf [2][2];
  int          mcnt [2];
  logic [31:0] cur [2];
  int          idx [2];
  bit          sv [2];
  bit          bv [2];
  logic [31:0] bd [2];
  bit          movf [2];

  function automatic logic [31:0] beat(int k);
    logic [31:0] m;
    m = (32'h1 << IW[k]) - 1;
    return (cur[k] >> (idx[k] * IW[k])) & m;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mcnt[k] = 0; cur[k] = '0; idx[k] = 0;
        sv[k] = 0; bv[k] = 0; bd[k] = '0; movf[k] = 0;
        mf[k][0] = '0; mf[k][1] = '0;
      end else begin
        bit pre_sv, rdy, fire, lst;
        int pre_n;
        pre_sv = sv[k];
        pre_n = mcnt[k];
        rdy = !bp && (mcnt[k] < 2);
        if (!bp) begin
          fire = sv[k] && ordy;
          lst = (idx[k] == NB[k] - 1);
          if (fire) begin
            if (!lst) idx[k]++;
            else sv[k] = 0;
          end
          if ((!pre_sv || (fire && lst)) && pre_n > 0) begin
            cur[k] = mf[k][0];
            mf[k][0] = mf[k][1];
            mcnt[k]--;
            idx[k] = 0;
            sv[k] = 1;
          end
          if (fv && rdy) begin
            mf[k][mcnt[k]] = fs & FM[k];
            mcnt[k]++;
          end
          if (fv && !rdy) movf[k] = 1;
        end
        bv[k] = iv;
        bd[k] = {24'h0, is} & ((32'h1 << IW[k]) - 1);
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic a_fr, a_ov, a_busy, a_ovf;
      logic [31:0] a_sp, e_sp;
      bit e_ov;
      a_fr   = (k == 0) ? fr0 : fr1;
      a_ov   = (k == 0) ? ov0 : ov1;
      a_busy = (k == 0) ? busy0 : busy1;
      a_ovf  = (k == 0) ? ovf0 : ovf1;
      a_sp   = (k == 0) ? {24'h0, sp0} : {28'h0, sp1};
      e_ov = bp ? bv[k] : sv[k];
      e_sp = bp ? bd[k] : beat(k);
      chk($sformatf("i%0d FRAME_READY", k), a_fr,
          !bp && (mcnt[k] < 2));
      chk($sformatf("i%0d OUT_VALID", k), a_ov, e_ov);
      chk($sformatf("i%0d BUSY", k), a_busy,
          (mcnt[k] > 0) || sv[k]);
      chk($sformatf("i%0d OVERFLOW", k), a_ovf, movf[k]);
      if (e_ov || rst)
        chk($sformatf("i%0d OUT_SPIKE", k), a_sp, e_sp);
    end
  end

  logic [7:0] log0 [$];
  int         lc0 [$];
  logic [7:0] log1 [$];

  always @(posedge clk) cyc++;

  // Record the beats that the next edge accepts.
  always @(negedge clk) begin
    if (!rst && !bp && ordy) begin
      if (ov0) begin
        log0.push_back(sp0);
        lc0.push_back(cyc);
      end
      if (ov1) log1.push_back({4'h0, sp1});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_logs();
    log0.delete();
    lc0.delete();
    log1.delete();
  endtask

  task automatic push_when_ready(input logic [31:0] f);
    int w;
    w = 0;
    while (!fr0 && w < 20) begin
      fv = 1'b0;
      tick();
      w++;
    end
    chk("push ready", fr0, 1'b1);
    fv = 1'b1;
    fs = f;
    tick();
  endtask

  task automatic chk_log0(input string nm, input logic [7:0] e [$]);
    chk({nm, " count"}, log0.size(), e.size());
    for (int i = 0; i < e.size() && i < log0.size(); i++)
      chk($sformatf("%s beat%0d", nm, i), log0[i], e[i]);
  endtask

  initial begin
    logic [7:0] e1 [8];
    e1 = '{8'hA, 8'h5, 8'h5, 8'hA, 8'h0, 8'h0, 8'h0, 8'h0};

    repeat (3) tick();
    chk("rst OUT_VALID0", ov0, 1'b0);
    chk("rst OUT_SPIKE0", sp0, 8'h00);
    chk("rst BUSY0", busy0, 1'b0);
    chk("rst OVERFLOW0", ovf0, 1'b0);
    chk("rst FRAME_READY0", fr0, 1'b1);
    chk("rst OUT_VALID1", ov1, 1'b0);
    chk("rst FRAME_READY1", fr1, 1'b1);
    rst = 1'b0;
    tick();

    // Single frame latency and beat order.
    clr_logs();
    ordy = 1'b1;
    fs = 32'h0000_A55A;
    fv = 1'b1;
    tick();
    fv = 1'b0;
    chk("t1 valid after E0", ov0, 1'b0);
    tick();
    chk("t1 valid after E1", ov0, 1'b1);
    chk("t1 beat0", sp0, 8'h5A);
    tick();
    chk("t1 beat1", sp0, 8'hA5);
    tick();
    chk("t1 valid after E3", ov0, 1'b0);
    chk("t1 busy after E3", busy0, 1'b0);
    repeat (10) tick();
    chk_log0("t1", '{8'h5A, 8'hA5});
    chk("t1 w4 count", log1.size(), 8);
    for (int i = 0; i < 8 && i < log1.size(); i++)
      chk($sformatf("t1 w4 beat%0d", i), log1[i], e1[i]);

    // Back-to-back frames, no bubble.
    clr_logs();
    push_when_ready(32'h1234);
    push_when_ready(32'h5678);
    push_when_ready(32'h9ABC);
    fv = 1'b0;
    repeat (30) tick();
    chk_log0("t2", '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A});
    for (int i = 1; i < lc0.size(); i++)
      chk($sformatf("t2 contiguous%0d", i), lc0[i] - lc0[0], i);
    chk("t2 overflow", ovf0, 1'b0);

    // Stall on beat 0.
    clr_logs();
    ordy = 1'b0;
    fs = 32'hBEEF;
    fv = 1'b1;
    tick();
    fv = 1'b0;
    tick();
    repeat (3) begin
      chk("t3 stall valid", ov0, 1'b1);
      chk("t3 stall beat", sp0, 8'hEF);
      tick();
    end
    ordy = 1'b1;
    repeat (30) tick();
    chk_log0("t3", '{8'hEF, 8'hBE});

    // Fill the FIFO, then offer one frame too many.
    clr_logs();
    ordy = 1'b0;
    push_when_ready(32'h2211);
    push_when_ready(32'h4433);
    push_when_ready(32'h6655);
    fv = 1'b0;
    chk("t4 full ready", fr0, 1'b0);
    chk("t4 no ovf yet", ovf0, 1'b0);
    fs = 32'h8877;
    fv = 1'b1;
    tick();
    fv = 1'b0;
    chk("t4 ovf set", ovf0, 1'b1);
    repeat (2) tick();
    chk("t4 ovf sticky", ovf0, 1'b1);
    ordy = 1'b1;
    repeat (30) tick();
    chk_log0("t4", '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66});
    chk("t4 ovf kept", ovf0, 1'b1);

    // Bypass in the middle of a frame.
    clr_logs();
    fs = 32'hC3D4;
    fv = 1'b1;
    tick();
    fv = 1'b0;
    tick();
    chk("t5 beat0", sp0, 8'hD4);
    tick();
    bp = 1'b1;
    iv = 1'b1;
    is = 8'h77;
    #1;
    chk("t5 bp ready", fr0, 1'b0);
    tick();
    chk("t5 bp valid", ov0, 1'b1);
    chk("t5 bp beat", sp0, 8'h77);
    iv = 1'b0;
    tick();
    chk("t5 bp idle", ov0, 1'b0);
    bp = 1'b0;
    #1;
    chk("t5 resume valid", ov0, 1'b1);
    chk("t5 resume beat", sp0, 8'hC3);
    repeat (30) tick();
    chk_log0("t5", '{8'hD4, 8'hC3});

    // Asynchronous reset during beat 0.
    ordy = 1'b0;
    fs = 32'h1357_5AC3;
    fv = 1'b1;
    tick();
    fv = 1'b0;
    tick();
    chk("t6 pre valid0", ov0, 1'b1);
    chk("t6 pre beat0", sp0, 8'hC3);
    chk("t6 pre beat1", sp1, 4'h3);
    rst = 1'b1;
    #1;
    chk("t6 async valid0", ov0, 1'b0);
    chk("t6 async spike0", sp0, 8'h00);
    chk("t6 async valid1", ov1, 1'b0);
    chk("t6 async spike1", sp1, 4'h0);
    chk("t6 async ovf0", ovf0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6 busy0", busy0, 1'b0);
    chk("t6 ready0", fr0, 1'b1);
    chk("t6 busy1", busy1, 1'b0);
    chk("t6 ready1", fr1, 1'b1);

    // Random traffic, model-checked every cycle.
    repeat (3000) begin
      fv = ($urandom_range(0, 2) != 0);
      fs = $urandom;
      ordy = ($urandom_range(0, 3) != 0);
      iv = $urandom_range(0, 1);
      is = 8'($urandom);
      if ($urandom_range(0, 19) == 0) bp = ~bp;
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    bp = 1'b0;
    fv = 1'b0;
    ordy = 1'b1;
    repeat (40) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
